// File: rtl/pipe_stage_reg_pkg.sv
// Shared CPU pipeline package: stage bundle types, their NOP values and pack helpers.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
    logic        jal;
    logic        start;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic        reg_we;
    logic        mem_we;
    logic        mem_re;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_we;
  } mem_wb_t;

  localparam int unsigned IF_ID_W  = $bits(if_id_t);
  localparam int unsigned ID_EX_W  = $bits(id_ex_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

  // Bubbles: all write enables low; IF/ID carries a canonical addi x0,x0,0.
  localparam if_id_t  IF_ID_NOP  = '{pc: 32'h0, instr: 32'h0000_0013};
  localparam id_ex_t  ID_EX_NOP  = '0;
  localparam ex_mem_t EX_MEM_NOP = '0;
  localparam mem_wb_t MEM_WB_NOP = '0;

  function automatic logic [ID_EX_W-1:0] pack_id_ex(input id_ex_t s);
    return ID_EX_W'(s);
  endfunction

  function automatic id_ex_t unpack_id_ex(input logic [ID_EX_W-1:0] v);
    return id_ex_t'(v);
  endfunction

  function automatic logic [EX_MEM_W-1:0] pack_ex_mem(input ex_mem_t s);
    return EX_MEM_W'(s);
  endfunction

  function automatic ex_mem_t unpack_ex_mem(input logic [EX_MEM_W-1:0] v);
    return ex_mem_t'(v);
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready stage bus carrying a packed bundle.
interface pipe_stage_reg_if #(
  parameter int unsigned WIDTH = 32
) ();
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_reg_skid.sv
// Two-entry skid stage: main register, skid register and registered in_ready.
module pipe_skid_buf
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  stage_state_e     state_q;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             rdy_q;

  // rdy_q tracks "next state is not SKID"; main_q always holds BUBBLE when EMPTY.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= ST_EMPTY;
      main_q  <= BUBBLE;
      skid_q  <= BUBBLE;
      rdy_q   <= 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_valid) begin
            state_q <= ST_FULL;
            main_q  <= in_data;
          end
        end
        ST_FULL: begin
          if (in_valid && out_ready) begin
            main_q <= in_data;
          end else if (in_valid) begin
            state_q <= ST_SKID;
            skid_q  <= in_data;
            rdy_q   <= 1'b0;
          end else if (out_ready) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
          end
        end
        ST_SKID: begin
          if (out_ready) begin
            state_q <= ST_FULL;
            main_q  <= skid_q;
            skid_q  <= BUBBLE;
            rdy_q   <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
          main_q  <= BUBBLE;
          skid_q  <= BUBBLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = rdy_q && !reset;
  assign out_valid = (state_q != ST_EMPTY);
  assign out_data  = main_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready back-pressure, flush, optional skid and stall counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned      WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter bit               SKID   = 1'b1,
  parameter int unsigned      CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  pipe_stage_reg_if.slave  up,
  pipe_stage_reg_if.master dn,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  if (SKID) begin : g_skid
    pipe_skid_buf #(
      .WIDTH  (WIDTH),
      .BUBBLE (BUBBLE)
    ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (up.valid),
      .in_data   (up.data),
      .in_ready  (in_ready),
      .out_ready (dn.ready),
      .out_valid (out_valid),
      .out_data  (out_data)
    );
  end else begin : g_reg
    stage_state_e     state_q;
    logic [WIDTH-1:0] main_q;
    logic             in_fire;
    logic             out_fire;

    assign in_ready = !out_valid || dn.ready;
    assign in_fire  = up.valid && in_ready;
    assign out_fire = out_valid && dn.ready;

    // Single register: load on input handshake, drop to bubble when drained.
    always_ff @(posedge clk) begin
      if (reset || flush) begin
        state_q <= ST_EMPTY;
        main_q  <= BUBBLE;
      end else if (in_fire) begin
        state_q <= ST_FULL;
        main_q  <= up.data;
      end else if (out_fire) begin
        state_q <= ST_EMPTY;
        main_q  <= BUBBLE;
      end
    end

    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
  end

  // Saturating stall counter; flush deliberately leaves it alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (out_valid && !dn.ready && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign up.ready = in_ready;
  assign dn.valid = out_valid;
  assign dn.data  = out_data;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a SKID=1 and a SKID=0 instance checked against a queue model.
module tb_pipe_stage_reg;

  localparam logic [31:0] BUB_A = 32'hDEAD_BEEF;
  localparam logic [31:0] BUB_B = 32'h0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush_a = 1'b0;
  logic        flush_b = 1'b0;
  logic [3:0]  stall_a;
  logic [15:0] stall_b;

  int n_vec = 0;
  int n_err = 0;

  // Model state: beats resident in each stage, in order, plus stall cycle counts.
  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int          cnt_a = 0;
  int          cnt_b = 0;

  pipe_stage_reg_if #(.WIDTH(32)) ia ();
  pipe_stage_reg_if #(.WIDTH(32)) oa ();
  pipe_stage_reg_if #(.WIDTH(32)) ib ();
  pipe_stage_reg_if #(.WIDTH(32)) ob ();

  pipe_stage_reg #(.WIDTH(32), .BUBBLE(BUB_A), .SKID(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .flush(flush_a), .up(ia), .dn(oa), .stall_cnt(stall_a)
  );

  pipe_stage_reg #(.WIDTH(32), .BUBBLE(BUB_B), .SKID(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .flush(flush_b), .up(ib), .dn(ob), .stall_cnt(stall_b)
  );

  always #5 clk = ~clk;

  // One clock: compare both DUTs with the model, then advance the model across the edge.
  task automatic cycle();
    logic        a_rm, b_rm, a_if, a_of, b_if, b_of;
    logic [31:0] exp_a, exp_b;
    #1;
    a_rm  = reset ? 1'b0 : (qa.size() < 2);
    b_rm  = (qb.size() == 0) || ob.ready;
    exp_a = (qa.size() != 0) ? qa[0] : BUB_A;
    exp_b = (qb.size() != 0) ? qb[0] : BUB_B;
    n_vec++; if (ia.ready !== a_rm) begin n_err++; $display("FAIL a_in_ready got %b want %b t=%0t", ia.ready, a_rm, $time); end
    n_vec++; if (oa.valid !== (qa.size() != 0)) begin n_err++; $display("FAIL a_out_valid got %b want %b t=%0t", oa.valid, (qa.size() != 0), $time); end
    n_vec++; if (oa.data !== exp_a) begin n_err++; $display("FAIL a_out_data got %h want %h t=%0t", oa.data, exp_a, $time); end
    n_vec++; if (stall_a !== 4'(cnt_a)) begin n_err++; $display("FAIL a_stall_cnt got %0d want %0d t=%0t", stall_a, cnt_a, $time); end
    n_vec++; if (ib.ready !== b_rm) begin n_err++; $display("FAIL b_in_ready got %b want %b t=%0t", ib.ready, b_rm, $time); end
    n_vec++; if (ob.valid !== (qb.size() != 0)) begin n_err++; $display("FAIL b_out_valid got %b want %b t=%0t", ob.valid, (qb.size() != 0), $time); end
    n_vec++; if (ob.data !== exp_b) begin n_err++; $display("FAIL b_out_data got %h want %h t=%0t", ob.data, exp_b, $time); end
    n_vec++; if (stall_b !== 16'(cnt_b)) begin n_err++; $display("FAIL b_stall_cnt got %0d want %0d t=%0t", stall_b, cnt_b, $time); end
    a_if = ia.valid && a_rm;
    a_of = (qa.size() != 0) && oa.ready;
    b_if = ib.valid && b_rm;
    b_of = (qb.size() != 0) && ob.ready;
    @(posedge clk);
    if (reset) begin
      qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
    end else begin
      if ((qa.size() != 0) && !oa.ready && cnt_a < 15) cnt_a++;
      if ((qb.size() != 0) && !ob.ready && cnt_b < 65535) cnt_b++;
      if (a_of) void'(qa.pop_front());
      if (b_of) void'(qb.pop_front());
      if (flush_a) qa.delete(); else if (a_if) qa.push_back(ia.data);
      if (flush_b) qb.delete(); else if (b_if) qb.push_back(ib.data);
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    ia.valid = 1'b0; ia.data = 32'h0; oa.ready = 1'b1; flush_a = 1'b0;
    ib.valid = 1'b0; ib.data = 32'h0; ob.ready = 1'b1; flush_b = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    ob.ready = 1'b0;
    cycle();
    n_vec++; if (ia.ready !== 1'b0 || ib.ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got a=%b b=%b want a=0 b=1", ia.ready, ib.ready); end
    reset = 1'b0;
    ob.ready = 1'b1;
    cycle();
    n_vec++; if (oa.valid !== 1'b0 || oa.data !== BUB_A || stall_a !== 4'd0 || ia.ready !== 1'b1) begin
      n_err++; $display("FAIL reset_state got v=%b d=%h c=%0d r=%b want v=0 d=%h c=0 r=1", oa.valid, oa.data, stall_a, ia.ready, BUB_A);
    end
  endtask

  task automatic test_stream();
    oa.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      ia.valid = 1'b1; ia.data = 32'(i);
      cycle();
      n_vec++; if (oa.data !== 32'(i) || oa.valid !== 1'b1 || ia.ready !== 1'b1) begin
        n_err++; $display("FAIL stream beat %0d got d=%h v=%b r=%b want d=%h v=1 r=1", i, oa.data, oa.valid, ia.ready, 32'(i));
      end
    end
    ia.valid = 1'b0;
    cycle();
  endtask

  task automatic test_back_pressure();
    logic [31:0] got[$];
    logic        sent;
    ia.valid = 1'b1; ia.data = 32'hA; oa.ready = 1'b1;
    cycle();
    ia.data = 32'hB; oa.ready = 1'b0;
    cycle();
    n_vec++; if (ia.ready !== 1'b0 || oa.data !== 32'hA) begin n_err++; $display("FAIL bp_skid got r=%b d=%h want r=0 d=a", ia.ready, oa.data); end
    ia.data = 32'hC;
    cycle();
    cycle();
    n_vec++; if (stall_a !== 4'd3 || oa.data !== 32'hA) begin n_err++; $display("FAIL bp_stall got c=%0d d=%h want c=3 d=a", stall_a, oa.data); end
    oa.ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (oa.valid) got.push_back(oa.data);
      sent = ia.valid && ia.ready;
      cycle();
      if (sent) ia.valid = 1'b0;
    end
    n_vec++; if (got.size() != 3 || got[0] !== 32'hA || got[1] !== 32'hB || got[2] !== 32'hC) begin
      n_err++; $display("FAIL bp_order got %0d beats first=%h want a,b,c", got.size(), (got.size() != 0) ? got[0] : 32'hx);
    end
  endtask

  task automatic test_flush_skid();
    logic d_seen;
    d_seen = 1'b0;
    ia.valid = 1'b1; ia.data = 32'hE; oa.ready = 1'b1;
    cycle();
    ia.data = 32'hF; oa.ready = 1'b0;
    cycle();
    ia.data = 32'hD; flush_a = 1'b1;
    cycle();
    flush_a = 1'b0; ia.valid = 1'b0;
    n_vec++; if (oa.valid !== 1'b0 || oa.data !== BUB_A || ia.ready !== 1'b1) begin
      n_err++; $display("FAIL flush_state got v=%b d=%h r=%b want v=0 d=%h r=1", oa.valid, oa.data, ia.ready, BUB_A);
    end
    oa.ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      if (oa.valid || oa.data === 32'hD) d_seen = 1'b1;
    end
    n_vec++; if (d_seen !== 1'b0) begin n_err++; $display("FAIL flush_discard got seen=%b want 0", d_seen); end
  endtask

  task automatic test_skid0_toggle();
    logic [2:0]  pat;
    logic [31:0] nxt;
    logic [31:0] got[$];
    logic        sent;
    pat = 3'b101;
    nxt = 32'h100;
    for (int k = 0; k < 12; k++) begin
      ob.ready = pat[k % 3];
      ib.valid = 1'b1; ib.data = nxt;
      #1;
      n_vec++; if (ib.ready !== (!ob.valid || ob.ready)) begin n_err++; $display("FAIL s0_ready k=%0d got %b want %b", k, ib.ready, (!ob.valid || ob.ready)); end
      if (ob.valid && ob.ready) got.push_back(ob.data);
      sent = ib.ready;
      cycle();
      if (sent) nxt = nxt + 32'd1;
    end
    ib.valid = 1'b0; ob.ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (ob.valid) got.push_back(ob.data);
      cycle();
    end
    n_vec++; if (got.size() != int'(nxt - 32'h100)) begin n_err++; $display("FAIL s0_count got %0d want %0d", got.size(), nxt - 32'h100); end
    foreach (got[i]) begin
      n_vec++; if (got[i] !== 32'h100 + 32'(i)) begin n_err++; $display("FAIL s0_order idx %0d got %h want %h", i, got[i], 32'h100 + 32'(i)); end
    end
  endtask

  task automatic test_reset_full();
    ia.valid = 1'b1; ia.data = 32'h55; oa.ready = 1'b1;
    cycle();
    ia.valid = 1'b0; oa.ready = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_vec++; if (oa.valid !== 1'b0 || oa.data !== 32'hDEADBEEF || stall_a !== 4'd0) begin
      n_err++; $display("FAIL reset_full got v=%b d=%h c=%0d want v=0 d=deadbeef c=0", oa.valid, oa.data, stall_a);
    end
    oa.ready = 1'b1;
    cycle();
  endtask

  task automatic test_saturation();
    ia.valid = 1'b1; ia.data = 32'h77; oa.ready = 1'b1;
    cycle();
    ia.valid = 1'b0; oa.ready = 1'b0;
    repeat (20) cycle();
    n_vec++; if (stall_a !== 4'd15) begin n_err++; $display("FAIL stall_sat got %0d want 15", stall_a); end
    oa.ready = 1'b1;
    cycle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      ia.valid = 1'($urandom_range(0, 1)); ia.data = $urandom;
      oa.ready = ($urandom_range(0, 3) != 0);
      flush_a  = ($urandom_range(0, 31) == 0);
      ib.valid = 1'($urandom_range(0, 1)); ib.data = $urandom;
      ob.ready = ($urandom_range(0, 3) != 0);
      flush_b  = ($urandom_range(0, 31) == 0);
      reset    = ($urandom_range(0, 199) == 0);
      cycle();
    end
    reset = 1'b0;
    idle_inputs();
    cycle();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    test_reset();
    test_stream();
    test_back_pressure();
    test_flush_skid();
    test_skid0_toggle();
    test_reset_full();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
